alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester controller that shares the single combinational 8-bit ALU between independent clients. Each request carries a 3-bit ALU instruction and two 8-bit operands; the block arbitrates round-robin, latches the winner's operation, drives the ALU for one cycle, captures the result and zero flag, and returns them over a valid/ready response channel tagged with the requester ID. It sits between the ALU and its clients (the main datapath and the auxiliary address/loop unit).

## Interface
- No parameters; data width fixed at 8, instruction width fixed at 3, requester count fixed at 2.

- clk  in  1  single clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_instr  in  3  requester 0 ALU instruction
- req0_a  in  8  requester 0 operand 1
- req0_b  in  8  requester 0 operand 2
- req1_valid, req1_ready, req1_instr, req1_a, req1_b  same as requester 0, for requester 1
- alu_instr  out  3  instruction to ALU
- alu_in1  out  8  operand 1 to ALU
- alu_in2  out  8  operand 2 to ALU
- alu_result  in  8  ALU result
- alu_zero  in  1  ALU zero flag
- rsp_valid  out  1  response holding
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester that issued the operation
- rsp_result  out  8  captured ALU result
- rsp_zero  out  1  captured ALU zero flag
- rsp_err  out  1  instruction was outside 0..4 (unsupported)
- busy  out  1  high in EXEC or RESP

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- Transitions:
  - IDLE: if any reqN_valid, grant one, latch {id, instr, a, b} into op registers, go EXEC; else stay.
  - EXEC: capture alu_result, alu_zero, err into response registers, go RESP. Unconditional, exactly one cycle.
  - RESP: rsp_valid=1. If rsp_ready=0, stay; all response outputs stable. If rsp_ready=1 and a reqN_valid is present, grant/latch as in IDLE and go EXEC (back-to-back). If rsp_ready=1 and no request, go IDLE.
- Arbitration: reqN_ready is combinational, high only for the granted requester in a cycle where a grant occurs (IDLE, or RESP with rsp_ready=1). Both ready never high together.
  - Only one valid: that requester wins.
  - Both valid: winner is requester `prio`. After any grant to k, prio <= ~k. prio resets to 0.
- Request protocol: reqN_valid is held until reqN_ready. Payload is stable while valid && !ready. Violations are undefined.
- ALU drive: alu_instr/alu_in1/alu_in2 always equal the op registers (reset 0), so the ALU sees the op throughout EXEC.
- rsp_err = 1 when the latched instr is 5, 6 or 7. The op is still executed; the ALU returns 0xFF for it, and that value is passed through unchanged.
- rsp_zero is the captured alu_zero. It is not recomputed.
- busy = (state != IDLE).

## Timing
- Reset values: req0_ready=0, req1_ready=0 (state IDLE, no valid), alu_instr=0, alu_in1=0, alu_in2=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, busy=0, prio=0.
- Latency: accept at edge N (valid&ready high in cycle N-1 sampled at N), EXEC during cycle N, rsp_valid high from cycle N+1.
- Throughput: one op per 2 cycles with rsp_ready held high. Back-to-back grant occurs in the RESP cycle.
- Backpressure: rsp_ready low stalls indefinitely. No request is accepted while stalled.
- Response registers update only at the EXEC→RESP edge.
- Reset mid-operation (any state) clears to IDLE immediately and asynchronously. In-flight op and pending response are discarded, and no response is emitted for them.
- All outputs except reqN_ready are registered or decoded from registered state.

## Test plan
- Single request: req0 xor a=0x5A b=0xFF, rsp_ready=1 -> req0_ready 1 cycle, rsp_valid 2 cycles after accept; rsp_id=0, rsp_result=0xA5, rsp_zero=0, rsp_err=0.
- Contention: both valid continuously, req0 addi 0x01+0x02, req1 andi 0xF0&0x0F, rsp_ready=1 -> grants alternate 0,1,0,1. Responses 0x03/zero=0 and 0x00/zero=1. A new grant every 2 cycles.
- Backpressure: response pending, rsp_ready=0 for 5 cycles while req1_valid high -> rsp_* stable, req1_ready stays 0. Raise rsp_ready -> req1 granted in that same cycle.
- Unsupported op: req1 instr=3'b110, a=0x12 -> rsp_err=1, rsp_result=0xFF, rsp_id=1.
- Shift/beq pass-through: instr=4, a=0x81, b=0x01 -> rsp_result=0x40. Then instr=1, a=b=0x33 -> rsp_result=0x00, rsp_zero=1.
- Async reset during RESP with rsp_ready=0 -> rsp_valid, busy, alu_* drop to 0 without a clock edge. The next request after deassert is granted to req0 when both are valid (prio reset).

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bundle of the client request channels, the ALU drive/return lines and the
// response channel of alu_arbiter. The slave modport is the arbiter's view.
interface alu_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [2:0] req0_instr;
  logic [7:0] req0_a;
  logic [7:0] req0_b;

  logic       req1_valid;
  logic       req1_ready;
  logic [2:0] req1_instr;
  logic [7:0] req1_a;
  logic [7:0] req1_b;

  logic [2:0] alu_instr;
  logic [7:0] alu_in1;
  logic [7:0] alu_in2;
  logic [7:0] alu_result;
  logic       alu_zero;

  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_result;
  logic       rsp_zero;
  logic       rsp_err;
  logic       busy;

  modport slave (
    input  req0_valid, req0_instr, req0_a, req0_b,
    input  req1_valid, req1_instr, req1_a, req1_b,
    input  alu_result, alu_zero, rsp_ready,
    output req0_ready, req1_ready,
    output alu_instr, alu_in1, alu_in2,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, busy
  );

  modport master (
    output req0_valid, req0_instr, req0_a, req0_b,
    output req1_valid, req1_instr, req1_a, req1_b,
    output alu_result, alu_zero, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_instr, alu_in1, alu_in2,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational 8-bit ALU between two clients;
// one operation in flight, result returned on a valid/ready response channel.
module alu_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic       id;
    logic [2:0] instr;
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  typedef struct packed {
    logic       id;
    logic [7:0] result;
    logic       zero;
    logic       err;
  } rsp_t;

  state_t state_q, state_d;
  logic   prio_q, prio_d;
  op_t    op_q, op_d;
  rsp_t   rsp_q, rsp_d;

  logic   any_valid;
  logic   grant_en;
  logic   grant_id;
  logic   ready0;
  logic   ready1;

  // With both clients pending the prio pointer decides; otherwise the only
  // valid one wins (grant_id is don't-care when nobody is valid).
  assign any_valid = bus.req0_valid | bus.req1_valid;
  assign grant_id  = (bus.req0_valid & bus.req1_valid) ? prio_q : bus.req1_valid;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    prio_d   = prio_q;
    op_d     = op_q;
    rsp_d    = rsp_q;
    grant_en = 1'b0;
    ready0   = 1'b0;
    ready1   = 1'b0;

    unique case (state_q)
      IDLE: begin
        grant_en = any_valid;
      end
      EXEC: begin
        rsp_d.id     = op_q.id;
        rsp_d.result = bus.alu_result;
        rsp_d.zero   = bus.alu_zero;
        rsp_d.err    = (op_q.instr >= 3'd5);
        state_d      = RESP;
      end
      RESP: begin
        // Response is consumed this cycle; a pending request is granted in
        // the same cycle so ops stream at one per two cycles.
        if (bus.rsp_ready) begin
          grant_en = any_valid;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (grant_en) begin
      state_d = EXEC;
      prio_d  = ~grant_id;
      ready0  = ~grant_id;
      ready1  = grant_id;
      if (grant_id) begin
        op_d = '{id: 1'b1, instr: bus.req1_instr, a: bus.req1_a, b: bus.req1_b};
      end else begin
        op_d = '{id: 1'b0, instr: bus.req0_instr, a: bus.req0_a, b: bus.req0_b};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      op_q    <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      op_q    <= op_d;
      rsp_q   <= rsp_d;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;

  assign bus.alu_instr  = op_q.instr;
  assign bus.alu_in1    = op_q.a;
  assign bus.alu_in2    = op_q.b;

  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = rsp_q.id;
  assign bus.rsp_result = rsp_q.result;
  assign bus.rsp_zero   = rsp_q.zero;
  assign bus.rsp_err    = rsp_q.err;
  assign bus.busy       = (state_q != IDLE);

  a_ready_excl : assert property (@(posedge clk) disable iff (!rst_n)
                                  !(bus.req0_ready && bus.req1_ready));

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: stimulus pushes hand-computed grants and
// responses into queues; negedge monitors pop and compare.
module tb_alu_arbiter;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_SRL = 3'd4;

  typedef struct {
    logic       id;
    logic [7:0] result;
    logic       zero;
    logic       err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;

  exp_t exp_q[$];
  logic grant_q[$];
  int   grant_cyc[$];

  logic [7:0] alu_r;

  alu_arbiter_if bus ();

  alu_arbiter u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU attached to the arbiter's ALU port.
  always_comb begin
    case (bus.alu_instr)
      3'd0:    alu_r = bus.alu_in1 + bus.alu_in2;
      3'd1:    alu_r = bus.alu_in1 - bus.alu_in2;
      3'd2:    alu_r = bus.alu_in1 & bus.alu_in2;
      3'd3:    alu_r = bus.alu_in1 ^ bus.alu_in2;
      3'd4:    alu_r = bus.alu_in1 >> bus.alu_in2[2:0];
      default: alu_r = 8'hFF;
    endcase
  end
  assign bus.alu_result = alu_r;
  assign bus.alu_zero   = (alu_r == 8'h00);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_op(input logic id, input logic [7:0] result, input logic zero,
                         input logic err);
    exp_t e;
    e.id = id; e.result = result; e.zero = zero; e.err = err;
    grant_q.push_back(id);
    exp_q.push_back(e);
  endtask

  function automatic logic ready_of(input logic id);
    return id ? bus.req1_ready : bus.req0_ready;
  endfunction

  task automatic drive_req(input logic id, input logic v, input logic [2:0] instr,
                           input logic [7:0] a, input logic [7:0] b);
    if (id) begin
      bus.req1_valid = v; bus.req1_instr = instr; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_instr = instr; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic id, input logic [2:0] instr, input logic [7:0] a,
                      input logic [7:0] b);
    bit got;
    got = 0;
    drive_req(id, 1'b1, instr, a, b);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready_of(id)) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL send_timeout: req%0d never got ready", id);
    end
    @(posedge clk);
    #1;
    drive_req(id, 1'b0, instr, a, b);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.busy && exp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy=%0d pending=%0d", bus.busy, exp_q.size());
    end
  endtask

  // Grant monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req0_ready || bus.req1_ready)
        check("ready_excl", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
      if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
        if (grant_q.size() == 0) begin
          total++; bad++;
          $display("FAIL grant_unexpected: got req%0d, want none", bus.req1_ready);
        end else begin
          check("grant_id", {31'd0, bus.req1_ready}, {31'd0, grant_q.pop_front()});
          grant_cyc.push_back(cyc);
        end
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp_unexpected: got id=%0d result=0x%0h, want none",
                 bus.rsp_id, bus.rsp_result);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id",     {31'd0, bus.rsp_id},     {31'd0, e.id});
        check("rsp_result", {24'd0, bus.rsp_result}, {24'd0, e.result});
        check("rsp_zero",   {31'd0, bus.rsp_zero},   {31'd0, e.zero});
        check("rsp_err",    {31'd0, bus.rsp_err},    {31'd0, e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b1;
    drive_req(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
    drive_req(1'b1, 1'b0, 3'd0, 8'd0, 8'd0);
    bus.rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values.
    check("rst_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
    check("rst_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
    check("rst_alu_instr",  {29'd0, bus.alu_instr},  32'd0);
    check("rst_alu_in1",    {24'd0, bus.alu_in1},    32'd0);
    check("rst_alu_in2",    {24'd0, bus.alu_in2},    32'd0);
    check("rst_rsp_valid",  {31'd0, bus.rsp_valid},  32'd0);
    check("rst_rsp_id",     {31'd0, bus.rsp_id},     32'd0);
    check("rst_rsp_result", {24'd0, bus.rsp_result}, 32'd0);
    check("rst_rsp_zero",   {31'd0, bus.rsp_zero},   32'd0);
    check("rst_rsp_err",    {31'd0, bus.rsp_err},    32'd0);
    check("rst_busy",       {31'd0, bus.busy},       32'd0);
    rst_n = 1'b1;

    // Single request with latency checks: xor 0x5A ^ 0xFF = 0xA5.
    push_op(1'b0, 8'hA5, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    drive_req(1'b0, 1'b1, OP_XOR, 8'h5A, 8'hFF);
    @(negedge clk);
    check("single_ready", {31'd0, bus.req0_ready}, 32'd1);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, OP_XOR, 8'h5A, 8'hFF);
    @(negedge clk);
    check("exec_busy",      {31'd0, bus.busy},      32'd1);
    check("exec_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("exec_alu_instr", {29'd0, bus.alu_instr}, {29'd0, OP_XOR});
    check("exec_alu_in1",   {24'd0, bus.alu_in1},   32'h5A);
    check("exec_alu_in2",   {24'd0, bus.alu_in2},   32'hFF);
    @(negedge clk);
    check("resp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    wait_idle();

    // Unsupported instruction from req1: 0xFF passed through, err set.
    push_op(1'b1, 8'hFF, 1'b0, 1'b1);
    @(posedge clk); #1;
    send(1'b1, 3'b110, 8'h12, 8'h34);
    wait_idle();

    // Contention: both held valid, prio is back at 0 -> grants 0,1,0,1.
    push_op(1'b0, 8'h03, 1'b0, 1'b0);
    push_op(1'b1, 8'h00, 1'b1, 1'b0);
    push_op(1'b0, 8'h03, 1'b0, 1'b0);
    push_op(1'b1, 8'h00, 1'b1, 1'b0);
    grant_cyc.delete();
    @(posedge clk); #1;
    fork
      begin
        send(1'b0, OP_ADD, 8'h01, 8'h02);
        send(1'b0, OP_ADD, 8'h01, 8'h02);
      end
      begin
        send(1'b1, OP_AND, 8'hF0, 8'h0F);
        send(1'b1, OP_AND, 8'hF0, 8'h0F);
      end
    join
    wait_idle();
    check("contention_grants", grant_cyc.size(), 32'd4);
    for (int i = 0; i + 1 < grant_cyc.size(); i++)
      check("grant_spacing", grant_cyc[i+1] - grant_cyc[i], 32'd2);

    // Backpressure: response held for 5 cycles while req1 waits.
    push_op(1'b0, 8'h30, 1'b0, 1'b0);
    push_op(1'b1, 8'h00, 1'b1, 1'b0);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    send(1'b0, OP_ADD, 8'h10, 8'h20);
    drive_req(1'b1, 1'b1, OP_XOR, 8'h0F, 8'h0F);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_req1_ready",  {31'd0, bus.req1_ready}, 32'd0);
      check("bp_rsp_valid",   {31'd0, bus.rsp_valid},  32'd1);
      check("bp_rsp_result",  {24'd0, bus.rsp_result}, 32'h30);
      check("bp_rsp_id",      {31'd0, bus.rsp_id},     32'd0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_grant_same_cycle", {31'd0, bus.req1_ready}, 32'd1);
    @(posedge clk); #1;
    drive_req(1'b1, 1'b0, OP_XOR, 8'h0F, 8'h0F);
    wait_idle();

    // Shift then beq-style subtract.
    push_op(1'b0, 8'h40, 1'b0, 1'b0);
    push_op(1'b0, 8'h00, 1'b1, 1'b0);
    @(posedge clk); #1;
    send(1'b0, OP_SRL, 8'h81, 8'h01);
    send(1'b0, OP_SUB, 8'h33, 8'h33);
    wait_idle();

    // Async reset during a stalled RESP; the op is discarded (grant only).
    grant_q.push_back(1'b0);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    send(1'b0, OP_ADD, 8'h11, 8'h22);
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_rsp_valid",  {31'd0, bus.rsp_valid},  32'd0);
    check("arst_busy",       {31'd0, bus.busy},       32'd0);
    check("arst_alu_instr",  {29'd0, bus.alu_instr},  32'd0);
    check("arst_alu_in1",    {24'd0, bus.alu_in1},    32'd0);
    check("arst_alu_in2",    {24'd0, bus.alu_in2},    32'd0);
    check("arst_rsp_result", {24'd0, bus.rsp_result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // prio was 1 before reset; after reset req0 must win.
    push_op(1'b0, 8'h0F, 1'b0, 1'b0);
    push_op(1'b1, 8'h3C, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    fork
      send(1'b0, OP_ADD, 8'h07, 8'h08);
      send(1'b1, OP_AND, 8'hFF, 8'h3C);
    join
    wait_idle();

    check("grant_q_empty", grant_q.size(), 32'd0);
    check("exp_q_empty",   exp_q.size(),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
